// File: rtl/obi_avalon_bridge.sv
// OBI (Ibex) to Avalon-MM pipelined bridge with outstanding tracking, in-order type FIFO and registered response.
// Latency: request is combinational pass-through; Avalon response to core_rvalid_o is 1 cycle.
// Backpressure: grant withheld on waitrequest or when MAX_OUTSTANDING are in flight. Build option: OBI_AVALON_RESP_ERR_EN.
module obi_avalon_bridge #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic              core_we_i,
  input  logic [DW/8-1:0]   core_be_i,
  input  logic [AW-1:0]     core_addr_i,
  input  logic [DW-1:0]     core_wdata_i,
  output logic              core_rvalid_o,
  output logic [DW-1:0]     core_rdata_o,
  output logic              core_err_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [AW-1:0]     avm_address_o,
  output logic [DW/8-1:0]   avm_byteenable_o,
  output logic [DW-1:0]     avm_writedata_o,
  input  logic              avm_waitrequest_i,
  input  logic              avm_readdatavalid_i,
  input  logic [DW-1:0]     avm_readdata_i,
  input  logic              avm_writeresponsevalid_i,
  input  logic [1:0]        avm_response_i,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              idle_o,
  output logic              proto_err_o,
  input  logic              proto_err_clr_i
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CNT_W-1:0]           count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] type_q;       // 1 = write, 0 = read
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic                       rvalid_q, err_q, proto_q;
  logic [DW-1:0]              rdata_q;

  logic can_issue, grant, fifo_empty, head_we;
  logic rd_match, wr_match, pop, proto_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // The FIFO occupancy always equals the outstanding count, so the count doubles as its fill level.
  assign can_issue  = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign grant      = core_req_i & can_issue & ~avm_waitrequest_i;
  assign fifo_empty = (count_q == '0);
  assign head_we    = type_q[rd_ptr_q];

  // Only a response whose kind matches the oldest outstanding transaction is accepted.
  assign rd_match  = avm_readdatavalid_i & ~fifo_empty & ~head_we;
  assign wr_match  = avm_writeresponsevalid_i & ~fifo_empty & head_we;
  assign pop       = rd_match | wr_match;
  assign proto_set = (avm_readdatavalid_i & ~rd_match) | (avm_writeresponsevalid_i & ~wr_match);

  assign avm_read_o       = core_req_i & ~core_we_i & can_issue;
  assign avm_write_o      = core_req_i & core_we_i & can_issue;
  assign avm_address_o    = core_addr_i;
  assign avm_byteenable_o = core_be_i;
  assign avm_writedata_o  = core_wdata_i;
  assign core_gnt_o       = grant;

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign outstanding_o = count_q;
  assign idle_o        = fifo_empty & ~rvalid_q;
  assign proto_err_o   = proto_q;

  // Next outstanding count: grant and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (grant && !pop)      count_d = count_q + CNT_W'(1);
    else if (!grant && pop) count_d = count_q - CNT_W'(1);
  end

  // Outstanding counter and response-type FIFO pointers/storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      type_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (grant) begin
        type_q[wr_ptr_q] <= core_we_i;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Registered response stage; write responses return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pop;
      rdata_q  <= rd_match ? avm_readdata_i : '0;
    end
  end

`ifdef OBI_AVALON_RESP_ERR_EN
  // Error flag captured alongside the accepted response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= pop & (avm_response_i != 2'b00);
  end
`else
  logic unused_response;
  assign unused_response = ^avm_response_i;
  assign err_q = 1'b0;
`endif
  assign core_err_o = err_q;

  // Sticky protocol-violation flag; a new violation beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              proto_q <= 1'b0;
    else if (proto_set)       proto_q <= 1'b1;
    else if (proto_err_clr_i) proto_q <= 1'b0;
  end

endmodule

// File: tb/tb_obi_avalon_bridge.sv
// Directed bench for obi_avalon_bridge (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge or #1 after an input change.
// Expected values are hand-computed per step.
module tb_obi_avalon_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        avm_read_o, avm_write_o;
  logic [31:0] avm_address_o, avm_writedata_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_waitrequest_i, avm_readdatavalid_i, avm_writeresponsevalid_i;
  logic [31:0] avm_readdata_i;
  logic [1:0]  avm_response_i;
  logic [2:0]  outstanding_o;
  logic        idle_o, proto_err_o, proto_err_clr_i;

  int checks = 0;
  int errors = 0;
  int grants;
  logic exp_err_slv;

  obi_avalon_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .avm_read_o(avm_read_o), .avm_write_o(avm_write_o), .avm_address_o(avm_address_o),
    .avm_byteenable_o(avm_byteenable_o), .avm_writedata_o(avm_writedata_o),
    .avm_waitrequest_i(avm_waitrequest_i), .avm_readdatavalid_i(avm_readdatavalid_i),
    .avm_readdata_i(avm_readdata_i), .avm_writeresponsevalid_i(avm_writeresponsevalid_i),
    .avm_response_i(avm_response_i), .outstanding_o(outstanding_o), .idle_o(idle_o),
    .proto_err_o(proto_err_o), .proto_err_clr_i(proto_err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef OBI_AVALON_RESP_ERR_EN
    exp_err_slv = 1'b1;
`else
    exp_err_slv = 1'b0;
`endif
    rst_ni = 1'b0;
    core_req_i = 0; core_we_i = 0; core_be_i = 4'hF; core_addr_i = 0; core_wdata_i = 0;
    avm_waitrequest_i = 0; avm_readdatavalid_i = 0; avm_readdata_i = 0;
    avm_writeresponsevalid_i = 0; avm_response_i = 2'b00; proto_err_clr_i = 0;
    #1;
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_rdata", core_rdata_o, 0);
    chk("rst_err", core_err_o, 0);
    chk("rst_proto", proto_err_o, 0);
    chk("rst_outst", outstanding_o, 0);
    chk("rst_idle", idle_o, 1);

    // Single read, response three cycles after grant
    @(negedge clk_i); rst_ni = 1'b1;
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h0000_0100;
    #1;
    chk("rd_gnt", core_gnt_o, 1);
    chk("rd_avm_read", avm_read_o, 1);
    chk("rd_avm_addr", avm_address_o, 32'h0000_0100);
    @(negedge clk_i); core_req_i = 0;
    chk("rd_outst1", outstanding_o, 1);
    chk("rd_idle0", idle_o, 0);
    @(negedge clk_i);
    @(negedge clk_i); avm_readdatavalid_i = 1; avm_readdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i); avm_readdatavalid_i = 0;
    chk("rd_rvalid", core_rvalid_o, 1);
    chk("rd_rdata", core_rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", core_err_o, 0);
    chk("rd_outst0", outstanding_o, 0);
    @(negedge clk_i);
    chk("rd_rvalid_1cyc", core_rvalid_o, 0);
    chk("rd_idle1", idle_o, 1);

    // Six back-to-back reads, no responses: only four grants
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk_i);
      core_req_i = 1; core_we_i = 0; core_addr_i = 32'h0000_1000 + 32'(4 * i);
      #1;
      if (core_gnt_o) grants++;
    end
    chk("full_grants", grants, 4);
    chk("full_outst", outstanding_o, 4);
    chk("full_avm_read", avm_read_o, 0);
    chk("full_gnt", core_gnt_o, 0);
    @(negedge clk_i); avm_readdatavalid_i = 1; avm_readdata_i = 32'h11;
    #1;
    chk("full_no_credit", core_gnt_o, 0);
    @(negedge clk_i); avm_readdatavalid_i = 0;
    #1;
    chk("full_regrant", core_gnt_o, 1);
    chk("full_rvalid", core_rvalid_o, 1);
    chk("full_rdata", core_rdata_o, 32'h11);
    @(negedge clk_i); core_req_i = 0;
    chk("full_outst_again", outstanding_o, 4);
    // Drain with back-to-back responses
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (i > 0) begin
        chk("drain_rvalid", core_rvalid_o, 1);
        chk("drain_rdata", core_rdata_o, 32'h20 + 32'(i - 1));
      end
      avm_readdatavalid_i = 1; avm_readdata_i = 32'h20 + 32'(i);
    end
    @(negedge clk_i); avm_readdatavalid_i = 0;
    chk("drain_rvalid_last", core_rvalid_o, 1);
    chk("drain_rdata_last", core_rdata_o, 32'h23);
    chk("drain_outst", outstanding_o, 0);

    // Interleaved W, R, W
    @(negedge clk_i);
    core_req_i = 1; core_we_i = 1; core_addr_i = 32'h200; core_wdata_i = 32'hCAFE_0001; core_be_i = 4'h3;
    #1;
    chk("w1_avm_write", avm_write_o, 1);
    chk("w1_wdata", avm_writedata_o, 32'hCAFE_0001);
    chk("w1_be", avm_byteenable_o, 4'h3);
    chk("w1_gnt", core_gnt_o, 1);
    @(negedge clk_i); core_we_i = 0; core_addr_i = 32'h204; core_be_i = 4'hF;
    #1;
    chk("r_avm_read", avm_read_o, 1);
    chk("r_avm_write", avm_write_o, 0);
    @(negedge clk_i); core_we_i = 1; core_addr_i = 32'h208; core_wdata_i = 32'hCAFE_0002;
    @(negedge clk_i); core_req_i = 0; core_we_i = 0;
    chk("wrw_outst", outstanding_o, 3);
    avm_writeresponsevalid_i = 1; avm_response_i = 2'b10;
    @(negedge clk_i); avm_writeresponsevalid_i = 0; avm_response_i = 2'b00;
    avm_readdatavalid_i = 1; avm_readdata_i = 32'h1234;
    chk("wrw_rv1", core_rvalid_o, 1);
    chk("wrw_rd1", core_rdata_o, 0);
    chk("wrw_err1", core_err_o, 32'(exp_err_slv));
    @(negedge clk_i); avm_readdatavalid_i = 0; avm_writeresponsevalid_i = 1;
    chk("wrw_rv2", core_rvalid_o, 1);
    chk("wrw_rd2", core_rdata_o, 32'h1234);
    chk("wrw_err2", core_err_o, 0);
    @(negedge clk_i); avm_writeresponsevalid_i = 0;
    chk("wrw_rv3", core_rvalid_o, 1);
    chk("wrw_rd3", core_rdata_o, 0);
    chk("wrw_outst0", outstanding_o, 0);
    chk("wrw_proto", proto_err_o, 0);

    // readdatavalid with empty FIFO
    @(negedge clk_i); avm_readdatavalid_i = 1; avm_readdata_i = 32'h55;
    @(negedge clk_i); avm_readdatavalid_i = 0;
    chk("empty_rvalid", core_rvalid_o, 0);
    chk("empty_proto", proto_err_o, 1);
    @(negedge clk_i);
    chk("empty_proto_held", proto_err_o, 1);
    proto_err_clr_i = 1;
    @(negedge clk_i); proto_err_clr_i = 0;
    chk("proto_clr", proto_err_o, 0);

    // Read response while a write is at the head: dropped, no pop
    core_req_i = 1; core_we_i = 1;
    @(negedge clk_i); core_req_i = 0; core_we_i = 0; avm_readdatavalid_i = 1;
    @(negedge clk_i); avm_readdatavalid_i = 0;
    chk("mis_rvalid", core_rvalid_o, 0);
    chk("mis_proto", proto_err_o, 1);
    chk("mis_outst", outstanding_o, 1);
    avm_writeresponsevalid_i = 1; proto_err_clr_i = 1;
    @(negedge clk_i); avm_writeresponsevalid_i = 0; proto_err_clr_i = 0;
    chk("mis_wr_rvalid", core_rvalid_o, 1);
    chk("mis_proto_clr", proto_err_o, 0);
    chk("mis_outst0", outstanding_o, 0);

    // Violation and clear in the same cycle: set wins
    avm_readdatavalid_i = 1; proto_err_clr_i = 1;
    @(negedge clk_i); avm_readdatavalid_i = 0; proto_err_clr_i = 0;
    chk("setwins_proto", proto_err_o, 1);

    // Reset with two reads outstanding, then a stray response
    core_req_i = 1; core_we_i = 0;
    @(negedge clk_i);
    @(negedge clk_i); core_req_i = 0;
    chk("rst2_outst", outstanding_o, 2);
    rst_ni = 1'b0;
    #1;
    chk("rst2_outst0", outstanding_o, 0);
    chk("rst2_idle", idle_o, 1);
    chk("rst2_proto", proto_err_o, 0);
    @(negedge clk_i); rst_ni = 1'b1; avm_readdatavalid_i = 1; avm_readdata_i = 32'h77;
    @(negedge clk_i); avm_readdatavalid_i = 0;
    chk("stray_proto", proto_err_o, 1);
    chk("stray_rvalid", core_rvalid_o, 0);
    chk("stray_outst", outstanding_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_avalon_bridge.md
Name: obi_avalon_bridge

Overview:
- Parametrised bridge between the Ibex OBI-style data/instruction port and an Avalon-MM pipelined master.
- Replaces the combinational req/gnt/rvalid glue in the core integration wrapper.
- Adds:
  - bounded outstanding-transaction tracking;
  - an in-order read/write response-type FIFO;
  - a registered response stage;
  - protocol-violation detection.
- One instance per core bus: instruction bus with writes unused, or data bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8; byte-enable width is DW/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; must be ≥1.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- core_req_i  in  1  OBI request.
- core_gnt_o  out  1  OBI grant.
- core_we_i  in  1  write enable.
- core_be_i  in  DW/8  byte enables.
- core_addr_i  in  AW  address.
- core_wdata_i  in  DW  write data.
- core_rvalid_o  out  1  response valid; one per granted request.
- core_rdata_o  out  DW  read data; 0 for write responses.
- core_err_o  out  1  response error.
- avm_read_o  out  1  Avalon read.
- avm_write_o  out  1  Avalon write.
- avm_address_o  out  AW  Avalon address.
- avm_byteenable_o  out  DW/8  Avalon byte enables.
- avm_writedata_o  out  DW  Avalon write data.
- avm_waitrequest_i  in  1  Avalon waitrequest.
- avm_readdatavalid_i  in  1  read response strobe.
- avm_readdata_i  in  DW  read data.
- avm_writeresponsevalid_i  in  1  write response strobe.
- avm_response_i  in  2  Avalon response code: 00 OKAY, 10 SLVERR, 11 DECERR.
- outstanding_o  out  CNT_W  current outstanding count.
- idle_o  out  1  high when count==0 and no response is pending in the output stage.
- proto_err_o  out  1  sticky protocol-violation flag.
- proto_err_clr_i  in  1  synchronous clear of proto_err_o.

Behaviour:
- Reset: single clock; asynchronous active-low reset on rst_ni.
  - All state clears: count=0, type FIFO empty, output stage empty.
  - Outputs at reset: core_rvalid_o=0, core_rdata_o=0, core_err_o=0, proto_err_o=0, outstanding_o=0, idle_o=1.
- Issue:
  - can_issue = (count < MAX_OUTSTANDING).
  - avm_read_o = core_req_i & ~core_we_i & can_issue.
  - avm_write_o = core_req_i & core_we_i & can_issue.
  - Address, byteenable and writedata pass through combinationally.
  - core_gnt_o = core_req_i & can_issue & ~avm_waitrequest_i.
  - On grant, push core_we_i into the type FIFO (depth MAX_OUTSTANDING).
- Response acceptance:
  - A response is "matching" when:
    - avm_readdatavalid_i=1 and the FIFO head is a read; or
    - avm_writeresponsevalid_i=1 and the FIFO head is a write.
  - On a matching response: pop the FIFO and load the output stage.
  - The next cycle drives core_rvalid_o=1 for exactly one cycle, with:
    - core_rdata_o = readdata for reads, 0 for writes;
    - core_err_o per the optional feature.
  - Latency: Avalon response edge to core_rvalid_o is 1 cycle; back-to-back responses yield back-to-back rvalid.
- Counter:
  - +1 on grant, −1 on pop; grant and pop in the same cycle leaves it unchanged.
  - Grant is allowed at count==MAX only if it is impossible; can_issue is evaluated on the registered count, so there is no same-cycle credit from a pop.
- Protocol violations: set proto_err_o, which holds until proto_err_clr_i.
  - Response while FIFO empty: dropped, no rvalid.
  - Response type ≠ head type: dropped, no pop.
  - readdatavalid and writeresponsevalid in the same cycle: the head-matching one is processed, the other is dropped.
- Simultaneous set and proto_err_clr_i in the same cycle: set wins.
- Reset mid-operation: in-flight Avalon responses that arrive after reset hit an empty FIFO and are dropped, setting proto_err_o; software clears it.
- Full: at count==MAX_OUTSTANDING:
  - avm_read_o and avm_write_o are 0;
  - core_gnt_o is 0;
  - the request is held by the core.

Optional Feature:
- OBI_AVALON_RESP_ERR_EN defined:
  - core_err_o = (avm_response_i != 2'b00), registered with the response.
  - Applies to reads and writes.
- Undefined:
  - core_err_o is constant 0 and avm_response_i is ignored.
  - Protocol checking is unchanged.

Test Plan:
- Single read, waitrequest=0, readdatavalid 3 cycles later with data 0xDEADBEEF:
  - gnt in cycle 0;
  - core_rvalid_o=1 one cycle after readdatavalid;
  - core_rdata_o=0xDEADBEEF, err=0, outstanding returns 0.
- MAX_OUTSTANDING=4, 6 back-to-back reads with no responses:
  - exactly 4 grants;
  - avm_read_o=0 and gnt=0 while outstanding_o=4;
  - one response produces exactly 1 further grant the following cycle.
- Interleaved W,R,W with responses in order (writeresp, readdatavalid 0x1234, writeresp):
  - three rvalids in order;
  - rdata 0, 0x1234, 0.
- With OBI_AVALON_RESP_ERR_EN, write response with avm_response_i=2'b10 → core_err_o=1 on its rvalid.
- Without OBI_AVALON_RESP_ERR_EN, the same stimulus → core_err_o=0.
- readdatavalid with FIFO empty:
  - no rvalid;
  - proto_err_o=1 next cycle and held;
  - proto_err_clr_i pulse → 0.
- Reset asserted with 2 reads outstanding:
  - outstanding_o=0 and idle_o=1 immediately;
  - a stray readdatavalid after reset release → proto_err_o=1, no rvalid.
